add_sub_acc_ctrl: RTL and testbench
===================================

Name: add_sub_acc_ctrl

Overview:
- Sequential control stage wrapped around the N-bit combinational adder/subtractor.
- Upstream side: accepts opcode/operand commands over a valid/ready handshake and drives the adder's A, B and Sel inputs.
- Downstream side: captures the adder's S, Co and Ov into an accumulator and flag registers, then presents the result over a valid/ready handshake.
- The adder itself stays external and connects through the Add_* ports.

Parameters:
- N, 4, datapath width. Must match the adder's N; N >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- In_valid  input  1  command valid
- In_ready  output  1  command accepted when In_valid && In_ready
- Op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- D  input  N  operand
- Add_A  output  N  to adder A
- Add_B  output  N  to adder B
- Add_Sel  output  1  to adder Sel (1 = subtract)
- Add_S  input  N  from adder S
- Add_Co  input  1  from adder Co
- Add_Ov  input  1  from adder Ov
- Out_valid  output  1  result valid
- Out_ready  input  1  downstream accepts the result
- Acc  output  N  accumulator value
- Co_flag  output  1  carry out (for SUB: 1 = no borrow)
- Ov_flag  output  1  signed overflow
- Z_flag  output  1  Acc == 0
- Neg_flag  output  1  Acc[N-1]

Behaviour:
- Clock and reset: single clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; Acc=0; Co_flag=0; Ov_flag=0; Z_flag=1; Neg_flag=0; Out_valid=0; internal op/operand regs=0.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - In_ready=1.
  - On In_valid: latch Op into op_r and D into d_r, go to EXEC.
- EXEC (exactly 1 cycle):
  - In_ready=0. Adder is driven with Add_A=Acc, Add_B=d_r, Add_Sel=(op_r==SUB).
  - On the clock edge leaving EXEC, update registers per op_r:
    - ADD/SUB: Acc<=Add_S, Co_flag<=Add_Co, Ov_flag<=Add_Ov.
    - LOAD: Acc<=d_r, Co_flag<=0, Ov_flag<=0. Adder outputs ignored.
    - CLEAR: Acc<=0, Co_flag<=0, Ov_flag<=0. Adder outputs ignored.
  - Z_flag and Neg_flag are registered from the new Acc value in the same edge.
  - Go to HOLD.
- HOLD:
  - Out_valid=1. Acc and all flags held stable. In_ready=0.
  - On Out_ready: go to IDLE, and Out_valid=0 next cycle.
- Adder drive outside EXEC: Add_A=Acc, Add_B=0, Add_Sel=0. Add_* inputs are not sampled.
- Latency: command accepted at edge t → Out_valid=1 from t+2. Minimum 3 cycles per command (accept, exec, hold with Out_ready=1).
- In_ready is combinational from state only (IDLE).
  - In_valid outside IDLE is ignored; the command is not consumed.
  - Out_valid depends only on state.
- Arithmetic: wrap-around modulo 2^N; no saturation.
  - Co for SUB follows the adder's two's-complement convention: Co=1 iff Acc >= d_r unsigned.
- Flags (Acc, Co_flag, Ov_flag, Z_flag, Neg_flag) change only on the EXEC→HOLD edge and on reset.
- Reset mid-operation (EXEC or HOLD): immediately to IDLE with reset values. The pending command and result are discarded.
- Out_ready while not in HOLD: ignored.

Test Plan:
- Reset then idle, N=4: Acc=0, Z_flag=1, Out_valid=0, In_ready=1, Add_Sel=0.
- LOAD 7, then ADD 1:
  - LOAD: Out_valid 2 cycles after accept; Acc=7, Co=0, Ov=0.
  - ADD 1: Acc=8 (1000), Co=0, Ov=1, Neg=1, Z=0.
- Add_* drive during EXEC: LOAD 15, ADD 1 → in EXEC Add_A=15, Add_B=1, Add_Sel=0; result Acc=0, Co=1, Ov=0, Z=1.
- Subtraction:
  - LOAD 3, SUB 5 → in EXEC Add_Sel=1; result Acc=14, Co=0, Ov=0, Neg=1.
  - LOAD 5, SUB 5 → Acc=0, Co=1, Z=1.
- Backpressure: hold Out_ready=0 for 5 cycles in HOLD with In_valid=1 and a new D.
  - Out_valid stays 1; Acc and flags stable; In_ready=0; the new command is not taken.
  - After Out_ready=1: IDLE, then the new command is accepted.
- Async reset: assert rst mid-EXEC of ADD after LOAD 6.
  - Outputs return to reset values immediately, with no clock edge required.
  - No Out_valid pulse; the next command after reset behaves normally.
- CLEAR after Ov=1 result: Acc=0, Co=0, Ov=0, Z=1, Neg=0.

Source files
------------

// File: rtl/add_sub_acc_ctrl.sv
// -----------------------------------------------------------------------------
// add_sub_acc_ctrl
//
// Sequential control stage wrapped around an external N-bit combinational
// adder/subtractor. Commands (opcode + operand) arrive over a valid/ready
// handshake, one command is executed against the accumulator using the
// external adder, and the result (accumulator + flags) is presented over a
// second valid/ready handshake until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. In_ready and Out_valid are functions of
// the FSM state only, so neither side has a combinational path to the other.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   In_valid   command valid
//   In_ready   command accepted when In_valid && In_ready (high in IDLE)
//   Op         opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   D          operand
//   Add_A      to adder A (always the accumulator)
//   Add_B      to adder B (latched operand during EXEC, else 0)
//   Add_Sel    to adder Sel (1 = subtract; only during EXEC of a SUB)
//   Add_S      from adder sum/difference
//   Add_Co     from adder carry out
//   Add_Ov     from adder signed overflow
//   Out_valid  result valid (high in HOLD)
//   Out_ready  downstream accepts the result
//   Acc        accumulator value
//   Co_flag    carry out (for SUB: 1 = no borrow)
//   Ov_flag    signed overflow
//   Z_flag     Acc == 0
//   Neg_flag   Acc[N-1]
// -----------------------------------------------------------------------------
module add_sub_acc_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [1:0]   Op,
    input  logic [N-1:0] D,
    output logic [N-1:0] Add_A,
    output logic [N-1:0] Add_B,
    output logic         Add_Sel,
    input  logic [N-1:0] Add_S,
    input  logic         Add_Co,
    input  logic         Add_Ov,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [N-1:0] Acc,
    output logic         Co_flag,
    output logic         Ov_flag,
    output logic         Z_flag,
    output logic         Neg_flag
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [1:0]   op_r;
    logic [N-1:0] d_r;

    logic         accept;
    logic [N-1:0] acc_next;
    logic         co_next;
    logic         ov_next;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-only handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        In_ready   = 1'b0;
        Out_valid  = 1'b0;
        case (state)
            IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Always exactly one cycle: the adder result is captured on
                // the edge that leaves this state.
                state_next = HOLD;
            end
            HOLD: begin
                Out_valid = 1'b1;
                if (Out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = (state == IDLE) && In_valid;

    // ------------------------------------------------------------------
    // Adder drive. Outside EXEC the adder sees Acc + 0 so its outputs are
    // quiet and predictable; they are never sampled there anyway.
    // ------------------------------------------------------------------
    always_comb begin
        Add_A   = Acc;
        Add_B   = '0;
        Add_Sel = 1'b0;
        if (state == EXEC) begin
            Add_B   = d_r;
            Add_Sel = (op_r == OP_SUB);
        end
    end

    // ------------------------------------------------------------------
    // Command register: captured only on the accepting edge, so a command
    // presented outside IDLE is left on the bus unconsumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= OP_LOAD;
            d_r  <= '0;
        end else if (accept) begin
            op_r <= Op;
            d_r  <= D;
        end
    end

    // ------------------------------------------------------------------
    // Result selection for the EXEC->HOLD edge
    // ------------------------------------------------------------------
    always_comb begin
        acc_next = Acc;
        co_next  = Co_flag;
        ov_next  = Ov_flag;
        case (op_r)
            OP_LOAD: begin
                acc_next = d_r;
                co_next  = 1'b0;
                ov_next  = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                acc_next = Add_S;
                co_next  = Add_Co;
                ov_next  = Add_Ov;
            end
            OP_CLEAR: begin
                acc_next = '0;
                co_next  = 1'b0;
                ov_next  = 1'b0;
            end
            default: begin
                acc_next = Acc;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator and flags. Z/Neg are registered from the new value in the
    // same edge so all five outputs switch together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Acc      <= '0;
            Co_flag  <= 1'b0;
            Ov_flag  <= 1'b0;
            Z_flag   <= 1'b1;
            Neg_flag <= 1'b0;
        end else if (state == EXEC) begin
            Acc      <= acc_next;
            Co_flag  <= co_next;
            Ov_flag  <= ov_next;
            Z_flag   <= (acc_next == '0);
            Neg_flag <= acc_next[N-1];
        end
    end

endmodule

// File: tb/tb_add_sub_acc_ctrl.sv
module tb_add_sub_acc_ctrl;
  localparam int N = 4;
  localparam int MOD = 1 << N;
  localparam int OP_LOAD = 0, OP_ADD = 1, OP_SUB = 2, OP_CLEAR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] d = '0;
  logic [N-1:0] add_a, add_b, add_s;
  logic         add_sel, add_co, add_ov;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] acc;
  logic         co_flag, ov_flag, z_flag, neg_flag;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  add_sub_acc_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .In_valid(in_valid), .In_ready(in_ready), .Op(op), .D(d),
    .Add_A(add_a), .Add_B(add_b), .Add_Sel(add_sel),
    .Add_S(add_s), .Add_Co(add_co), .Add_Ov(add_ov),
    .Out_valid(out_valid), .Out_ready(out_ready),
    .Acc(acc), .Co_flag(co_flag), .Ov_flag(ov_flag),
    .Z_flag(z_flag), .Neg_flag(neg_flag)
  );

  // ---------------- external adder/subtractor ----------------
  logic [N-1:0] bx;
  logic [N:0]   sum_full;
  always_comb begin
    bx       = add_sel ? ~add_b : add_b;
    sum_full = {1'b0, add_a} + {1'b0, bx} + {{N{1'b0}}, add_sel};
    add_s    = sum_full[N-1:0];
    add_co   = sum_full[N];
    add_ov   = (add_a[N-1] == bx[N-1]) && (add_s[N-1] != add_a[N-1]);
  end

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic int sval(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  function automatic int f_acc(input int o, input int a, input int x);
    case (o)
      OP_LOAD: return x;
      OP_ADD:  return (a + x) % MOD;
      OP_SUB:  return (a - x + MOD) % MOD;
      default: return 0;
    endcase
  endfunction

  function automatic int f_co(input int o, input int a, input int x);
    if (o == OP_ADD) return (a + x >= MOD) ? 1 : 0;
    if (o == OP_SUB) return (a >= x) ? 1 : 0;
    return 0;
  endfunction

  function automatic int f_ov(input int o, input int a, input int x);
    int s;
    if (o == OP_ADD) s = sval(a) + sval(x);
    else if (o == OP_SUB) s = sval(a) - sval(x);
    else return 0;
    return (s > MOD / 2 - 1 || s < -(MOD / 2)) ? 1 : 0;
  endfunction

  int m_acc, m_co, m_ov, c_op, c_d;
  bit exec_now, holding;

  // One command in flight at a time: accepted, computed one cycle later,
  // then held until the consumer takes it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0; m_co <= 0; m_ov <= 0; c_op <= 0; c_d <= 0;
      exec_now <= 0; holding <= 0;
    end else if (exec_now) begin
      m_acc <= f_acc(c_op, m_acc, c_d);
      m_co  <= f_co(c_op, m_acc, c_d);
      m_ov  <= f_ov(c_op, m_acc, c_d);
      exec_now <= 0;
      holding  <= 1;
    end else if (holding) begin
      if (out_ready) holding <= 0;
    end else if (in_valid) begin
      c_op <= int'(op);
      c_d  <= int'(d);
      exec_now <= 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready",  int'(in_ready),  (!exec_now && !holding) ? 1 : 0);
    check("out_valid", int'(out_valid), holding ? 1 : 0);
    check("acc",       int'(acc),       m_acc);
    check("co_flag",   int'(co_flag),   m_co);
    check("ov_flag",   int'(ov_flag),   m_ov);
    check("z_flag",    int'(z_flag),    (m_acc == 0) ? 1 : 0);
    check("neg_flag",  int'(neg_flag),  (m_acc >= MOD / 2) ? 1 : 0);
    check("add_a",     int'(add_a),     m_acc);
    check("add_b",     int'(add_b),     exec_now ? c_d : 0);
    check("add_sel",   int'(add_sel),   (exec_now && c_op == OP_SUB) ? 1 : 0);
  end

  // ---------------- driver tasks ----------------
  int ex_a, ex_b, ex_sel;

  // Present a command, wait for acceptance, record the adder drive in EXEC
  // and return at the negedge of the first HOLD cycle with Out_ready low.
  task automatic issue(input int o, input int x);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: in_ready stayed %0d, required 1", in_ready);
    end
    in_valid = 1'b1;
    op = o[1:0];
    d = x[N-1:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ex_a = int'(add_a);
    ex_b = int'(add_b);
    ex_sel = int'(add_sel);
    check("lat_exec_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_hold_out_valid", int'(out_valid), 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int a, input int c,
                               input int v, input int z, input int ng);
    check({tag, "_acc"}, int'(acc), a);
    check({tag, "_co"},  int'(co_flag), c);
    check({tag, "_ov"},  int'(ov_flag), v);
    check({tag, "_z"},   int'(z_flag), z);
    check({tag, "_neg"}, int'(neg_flag), ng);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_acc", int'(acc), 0);
    check("rst_z", int'(z_flag), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_add_sel", int'(add_sel), 0);

    // LOAD 7, ADD 1 -> overflow into the sign bit
    issue(OP_LOAD, 7);
    expect_result("load7", 7, 0, 0, 0, 0);
    release_out();
    issue(OP_ADD, 1);
    expect_result("add1", 8, 0, 1, 0, 1);
    release_out();
    // CLEAR after an overflowed result
    issue(OP_CLEAR, 5);
    expect_result("clear", 0, 0, 0, 1, 0);
    release_out();

    // Adder drive during EXEC, carry out to zero
    issue(OP_LOAD, 15);
    release_out();
    issue(OP_ADD, 1);
    check("exec_add_a", ex_a, 15);
    check("exec_add_b", ex_b, 1);
    check("exec_add_sel", ex_sel, 0);
    expect_result("add_wrap", 0, 1, 0, 1, 0);
    release_out();

    // Subtraction with and without borrow
    issue(OP_LOAD, 3);
    release_out();
    issue(OP_SUB, 5);
    check("exec_sub_sel", ex_sel, 1);
    expect_result("sub_borrow", 14, 0, 0, 0, 1);
    release_out();
    issue(OP_LOAD, 5);
    release_out();
    issue(OP_SUB, 5);
    expect_result("sub_equal", 0, 1, 0, 1, 0);
    release_out();

    // Backpressure: a new command waits while the result is held
    issue(OP_LOAD, 9);
    in_valid = 1'b1;
    op = 2'(OP_ADD);
    d = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_acc", int'(acc), 9);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_exec_add_b", int'(add_b), 3);
    @(negedge clk);
    check("bp_result", int'(acc), 12);
    release_out();

    // Asynchronous reset in the middle of EXEC
    issue(OP_LOAD, 6);
    release_out();
    in_valid = 1'b1;
    op = 2'(OP_ADD);
    d = 4'd2;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_acc", int'(acc), 0);
    check("arst_z", int'(z_flag), 1);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_add_b", int'(add_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_pulse", int'(out_valid), 0);
    end
    issue(OP_LOAD, 4);
    expect_result("post_rst", 4, 0, 0, 0, 0);
    release_out();

    // Randomized free-running traffic on both handshakes
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      op        = 2'($urandom_range(0, 3));
      d         = N'($urandom_range(0, MOD - 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
